// File: rtl/scope_capture_ctrl.sv
// Logic-analyser style capture controller: arm on an edge or force, sample a probe pin into a
// byte buffer, then stream the buffer out over a serial transmitter. Define SCOPE_HEADER_EN to
// prefix each frame with 0xA5 and DEPTH_BYTES-1.
module scope_capture_ctrl #(
  parameter int unsigned DEPTH_BYTES = 64,
  parameter logic [7:0]  DIV_RESET   = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  input  logic       input_pin,
  output logic [1:0] state_out,
  output logic       done
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned IW = AW + 2;
`ifdef SCOPE_HEADER_EN
  localparam int unsigned FrameLen = DEPTH_BYTES + 2;
`else
  localparam int unsigned FrameLen = DEPTH_BYTES;
`endif
  localparam logic [IW-1:0] LastIdx = IW'(FrameLen - 1);
  localparam logic [AW-1:0] LastWr  = AW'(DEPTH_BYTES - 1);

  localparam logic [7:0] CmdArmRise = 8'h41;
  localparam logic [7:0] CmdArmFall = 8'h46;
  localparam logic [7:0] CmdForce   = 8'h4E;
  localparam logic [7:0] CmdAbort   = 8'h53;
  localparam logic [7:0] CmdSetDiv  = 8'h44;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StSend    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, s_in_q, s_prev_q;
  logic [7:0]    div_q, div_d;
  logic          div_pend_q, div_pend_d;
  logic          falling_q, falling_d;
  logic [7:0]    tick_q, tick_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          guard_q;
  logic [7:0]    last_tx_q;
  logic [7:0]    mem_q [DEPTH_BYTES];

  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    send_byte;
  logic          edge_hit, sample, strobe, abort;

  assign edge_hit = falling_q ? (s_prev_q & ~s_in_q) : (~s_prev_q & s_in_q);
  // Tick 0 is the sampling point so the very first CAPTURE cycle takes a sample.
  assign sample   = (state_q == StCapture) && (tick_q == 8'd0);
  assign strobe   = (state_q == StSend) && !guard_q && !tx_busy;
  assign abort    = new_rx_data && (rx_data == CmdAbort);

  assign new_tx_data = strobe;
  assign done        = strobe && (rd_idx_q == LastIdx);
  assign tx_data     = strobe ? send_byte : last_tx_q;
  assign state_out   = state_q;

  always_comb begin
    send_byte = mem_q[rd_idx_q[AW-1:0]];
`ifdef SCOPE_HEADER_EN
    if (rd_idx_q == '0) begin
      send_byte = 8'hA5;
    end else if (rd_idx_q == IW'(1)) begin
      send_byte = 8'(DEPTH_BYTES - 1);
    end else begin
      send_byte = mem_q[AW'(rd_idx_q - IW'(2))];
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_pend_d = div_pend_q;
    falling_d  = falling_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_idx_d   = rd_idx_q;
    mem_we     = 1'b0;
    mem_wdata  = {s_in_q, shift_q[7:1]};

    unique case (state_q)
      StIdle: begin
        if (new_rx_data) begin
          if (div_pend_q) begin
            div_pend_d = 1'b0;
            if (rx_data != CmdAbort) div_d = rx_data;
          end else begin
            case (rx_data)
              CmdArmRise: begin
                state_d   = StArmed;
                falling_d = 1'b0;
              end
              CmdArmFall: begin
                state_d   = StArmed;
                falling_d = 1'b1;
              end
              CmdForce:  state_d    = StCapture;
              CmdSetDiv: div_pend_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
      StArmed: begin
        if (edge_hit || (new_rx_data && rx_data == CmdForce)) state_d = StCapture;
      end
      StCapture: begin
        tick_d = (tick_q == div_q) ? 8'd0 : tick_q + 8'd1;
        if (sample) begin
          shift_d   = mem_wdata;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == LastWr) state_d = StSend;
          end
        end
      end
      StSend: begin
        if (strobe) begin
          if (rd_idx_q == LastIdx) state_d = StIdle;
          else                     rd_idx_d = rd_idx_q + IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d    = StIdle;
      div_pend_d = 1'b0;
    end
    // Every path back to IDLE leaves the capture/readout pointers clean for the next frame.
    if (state_d == StIdle) begin
      tick_d    = 8'd0;
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
      wr_ptr_d  = '0;
      rd_idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      s_in_q     <= 1'b0;
      s_prev_q   <= 1'b0;
      div_q      <= DIV_RESET;
      div_pend_q <= 1'b0;
      falling_q  <= 1'b0;
      tick_q     <= 8'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      wr_ptr_q   <= '0;
      rd_idx_q   <= '0;
      guard_q    <= 1'b0;
      last_tx_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= input_pin;
      s_in_q     <= sync1_q;
      s_prev_q   <= s_in_q;
      div_q      <= div_d;
      div_pend_q <= div_pend_d;
      falling_q  <= falling_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_idx_q   <= rd_idx_d;
      guard_q    <= strobe;
      if (strobe) last_tx_q <= send_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Scoreboard bench for scope_capture_ctrl: a pin-waveform reference model predicts every frame
// byte; a monitor pops and compares on each transmit strobe.
module tb_scope_capture_ctrl;

  localparam int unsigned DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       new_rx_data = 1'b0;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy = 1'b0;
  logic       input_pin = 1'b0;
  logic [1:0] state_out;
  logic       done;

  always #10 clk = ~clk;

  scope_capture_ctrl #(
    .DEPTH_BYTES(DEPTH),
    .DIV_RESET  (8'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .new_rx_data(new_rx_data),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .tx_busy    (tx_busy),
    .input_pin  (input_pin),
    .state_out  (state_out),
    .done       (done)
  );

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t       exp_q[$];
  logic       wave[$];
  int         passed = 0;
  int         total = 0;
  int         cyc = 0;
  int         frame_strobes = 0;
  int         strobe_total = 0;
  int         done_cnt = 0;
  int         last_strobe_cyc = 0;
  int         busy_mode = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] last_tx = 8'd0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // tx_busy driver: 0 = idle, 1 = random, 2 = held busy
  initial forever begin
    @(posedge clk);
    #2;
    case (busy_mode)
      0:       tx_busy = 1'b0;
      1:       tx_busy = ($urandom_range(0, 2) == 0);
      default: tx_busy = 1'b1;
    endcase
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    cyc++;
    if (new_tx_data) begin
      chk(!prev_strobe && !tx_busy, "handshake", {prev_strobe, tx_busy}, 0);
      if (busy_mode == 0 && frame_strobes > 0)
        chk(cyc - last_strobe_cyc == 2, "strobe_gap", cyc - last_strobe_cyc, 2);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_strobe", tx_data, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(tx_data == e.data, "tx_data", tx_data, e.data);
        chk(done == e.last, "done", done, e.last);
        last_tx = e.data;
      end
      frame_strobes++;
      strobe_total++;
      last_strobe_cyc = cyc;
      if (done) begin
        frame_strobes = 0;
        done_cnt++;
      end
    end else if (done) begin
      chk(1'b0, "done_without_strobe", done, 0);
    end
    prev_strobe = new_tx_data;
  end

  task automatic send_cmd(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    new_rx_data = 1'b1;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
  endtask

  task automatic set_div(input int dv);
    send_cmd(8'h44);
    send_cmd(8'(dv));
  endtask

  // kind: 0 random pin, 1 pin held high, 2 alternating runs of four clocks starting high.
  // The pin is held at the inactive level before cycle c0+8, so an arm edge is guaranteed there.
  task automatic run_frame(input logic [7:0] cmd, input int dv, input int kind,
                           input logic [7:0] junk);
    int   c0;
    int   len;
    int   f;
    logic lvl;
    logic [7:0] v;
    c0  = 4;
    len = c0 + 12 + 8 * DEPTH * (dv + 1);
    wave.delete();
    lvl = (cmd == 8'h46);
    for (int i = 0; i < len; i++) begin
      if (kind == 1) begin
        wave.push_back(1'b1);
      end else if (i < c0 + 8) begin
        wave.push_back(lvl);
      end else if (i == c0 + 8) begin
        lvl = ~lvl;
        wave.push_back(lvl);
      end else if (kind == 2) begin
        wave.push_back((((i - c0 - 8) / 4) % 2) == 0);
      end else begin
        if ($urandom_range(0, 2) == 0) lvl = ~lvl;
        wave.push_back(lvl);
      end
    end
    // Pin value wave[i] is seen as the synchronized input two cycles later; a command in cycle
    // c0 takes effect in cycle c0+1, and an edge seen in cycle c starts capture in cycle c+1.
    f = -1;
    if (cmd == 8'h4E) begin
      f = c0 + 1;
    end else begin
      for (int c = c0 + 1; c < len; c++) begin
        if (wave[c-3] != wave[c-2] && wave[c-2] == (cmd == 8'h41)) begin
          f = c + 1;
          break;
        end
      end
    end
`ifdef SCOPE_HEADER_EN
    exp_q.push_back('{data: 8'hA5, last: 1'b0});
    exp_q.push_back('{data: 8'(DEPTH - 1), last: 1'b0});
`endif
    for (int b = 0; b < DEPTH; b++) begin
      v = 8'd0;
      for (int k = 0; k < 8; k++) v[k] = wave[f + (b * 8 + k) * (dv + 1) - 2];
      exp_q.push_back('{data: v, last: (b == DEPTH - 1)});
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      input_pin   = wave[i];
      new_rx_data = (i == c0) || (i == c0 + 30);
      rx_data     = (i == c0) ? cmd : junk;
    end
  endtask

  task automatic wait_frame(input string name);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(done_cnt != start, name, n, 0);
    @(negedge clk);
    chk(state_out == 2'd0, "idle_after_done", state_out, 0);
    chk(exp_q.size() == 0, "frame_drained", exp_q.size(), 0);
  endtask

  // Returns at #1 into the guard cycle that follows strobe number >= target.
  task automatic wait_strobes(input int target, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(prev_strobe && frame_strobes >= target) && n < 4000);
    chk(n < 4000, name, n, 0);
    #1;
  endtask

  function automatic logic [7:0] rand_cmd();
    case ($urandom_range(0, 2))
      0:       return 8'h41;
      1:       return 8'h46;
      default: return 8'h4E;
    endcase
  endfunction

  function automatic logic [7:0] rand_junk();
    case ($urandom_range(0, 3))
      0:       return 8'h41;
      1:       return 8'h46;
      2:       return 8'h4E;
      default: return 8'h44;
    endcase
  endfunction

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int hit;
    int s0;
    int n;
    int dv;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(state_out == 2'd0, "rst_state", state_out, 0);
    chk(new_tx_data == 1'b0, "rst_strobe", new_tx_data, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(tx_data == 8'h00, "rst_tx_data", tx_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // div=0, forced frame with the pin held high: all 0xFF, back-to-back strobes
    set_div(0);
    run_frame(8'h4E, 0, 1, 8'h41);
    wait_frame("frame_ones");

    // div=3, arm rising, 10101010 held four clocks per bit: every byte 0x55
    set_div(3);
    run_frame(8'h41, 3, 2, 8'h4E);
    wait_frame("frame_alt");

    // Random arms, dividers and transmitter backpressure
    for (int r = 0; r < 3; r++) begin
      dv = $urandom_range(0, 3);
      set_div(dv);
      busy_mode = 1;
      run_frame(rand_cmd(), dv, 0, rand_junk());
      wait_frame("frame_random");
      busy_mode = 0;
    end

    // Armed for falling edge with the pin held high: stays ARMED, then one edge starts capture
    set_div(0);
    @(posedge clk); #1;
    input_pin = 1'b1;
    repeat (4) @(posedge clk);
    send_cmd(8'h46);
    s0 = strobe_total;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (state_out != 2'd1) bad++;
    end
    chk(bad == 0, "armed_hold", bad, 0);
    chk(strobe_total == s0, "armed_no_strobe", strobe_total - s0, 0);
    @(posedge clk); #1;
    input_pin = 1'b0;
    hit = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (state_out == 2'd2 && hit < 0) hit = k;
    end
    chk(hit >= 0 && hit <= 3, "edge_to_capture", hit, 3);
    send_cmd(8'h53);
    @(negedge clk);
    chk(state_out == 2'd0, "abort_capture", state_out, 0);

    // Transmitter held busy for 500 cycles in SEND
    busy_mode = 2;
    repeat (2) @(posedge clk);
    run_frame(8'h4E, 0, 0, rand_junk());
    n = 0;
    while (state_out != 2'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(state_out == 2'd3, "enter_send", state_out, 3);
    s0 = strobe_total;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx_data !== last_tx || new_tx_data) bad++;
    end
    chk(bad == 0, "busy_hold", bad, 0);
    busy_mode = 0;
    hit = 0;
    repeat (2) begin
      @(negedge clk);
      if (strobe_total != s0 || new_tx_data) hit = 1;
    end
    chk(hit == 1, "busy_release", hit, 1);
    wait_frame("frame_busy");

    // Abort after the tenth byte, then a fresh frame
    set_div(1);
    run_frame(8'h4E, 1, 0, rand_junk());
    wait_strobes(10, "reach_byte10");
    rx_data = 8'h53;
    new_rx_data = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    new_rx_data = 1'b0;
    frame_strobes = 0;
    @(negedge clk);
    chk(state_out == 2'd0, "abort_send", state_out, 0);
    s0 = strobe_total;
    repeat (50) @(negedge clk);
    chk(strobe_total == s0, "no_strobe_after_abort", strobe_total - s0, 0);
    set_div(0);
    run_frame(8'h4E, 0, 0, rand_junk());
    wait_frame("frame_after_abort");

    // Reset in the middle of SEND; the divider returns to its reset value (0)
    set_div(2);
    run_frame(8'h4E, 2, 0, rand_junk());
    wait_strobes(5, "reach_byte5");
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk(state_out == 2'd0, "midrst_state", state_out, 0);
    chk(tx_data == 8'h00, "midrst_tx_data", tx_data, 0);
    chk(new_tx_data == 1'b0 && done == 1'b0, "midrst_strobe", {new_tx_data, done}, 0);
    last_tx = 8'h00;
    frame_strobes = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(new_tx_data == 1'b0, "no_strobe_after_rst", new_tx_data, 0);
    run_frame(8'h4E, 0, 0, rand_junk());
    wait_frame("frame_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
